// File: rtl/lifo_stack.sv
`default_nettype none
// ============================================================================
//  Module      : lifo_stack
//  Description : Parametrised LIFO stack with a registered top-of-stack,
//                simultaneous push+pop (replace-top), occupancy count,
//                sticky overflow/underflow flags and an optional
//                overwrite-oldest (circular) mode for call/return use.
//  Revision    : 1.0 - initial release
// ============================================================================
module lifo_stack #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 3,
    parameter int OVERWRITE  = 0
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  en,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      din,
    input  logic                  err_clr,
    output logic [WIDTH-1:0]      top,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow,
    output logic                  underflow
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int                    c_DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   c_CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   c_CNT_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2:0]   c_CNT_ZERO = '0;
    localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE  = DEPTH_LOG2'(1);
    localparam logic [WIDTH-1:0]      c_TOP_ZERO = '0;

    // ------------------------------------------------------------------------
    // State
    //   r_ptr holds the index of the top entry while the stack is occupied;
    //   while empty it holds the slot the next push will write. Indices are
    //   kept modulo DEPTH, so in circular mode the bottom is implicit at
    //   (r_ptr - r_count + 1) mod DEPTH.
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0]      r_mem [c_DEPTH];
    logic [DEPTH_LOG2-1:0] r_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic [WIDTH-1:0]      r_top;
    logic                  r_overflow;
    logic                  r_underflow;

    // ------------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------------
    logic                  w_empty;
    logic                  w_full;
    logic [DEPTH_LOG2-1:0] w_ptr_inc;
    logic [DEPTH_LOG2-1:0] w_ptr_dec;
    logic                  w_wr_en;
    logic [DEPTH_LOG2-1:0] w_wr_idx;
    logic [DEPTH_LOG2-1:0] w_ptr_nxt;
    logic [DEPTH_LOG2:0]   w_cnt_nxt;
    logic [WIDTH-1:0]      w_top_nxt;
    logic                  w_set_ov;
    logic                  w_set_un;
    logic                  w_ov_nxt;
    logic                  w_un_nxt;

    // Status decoded straight from the registered count (no extra latency).
    assign w_empty   = (r_count == c_CNT_ZERO);
    assign w_full    = (r_count == c_CNT_FULL);
    assign w_ptr_inc = r_ptr + c_PTR_ONE;
    assign w_ptr_dec = r_ptr - c_PTR_ONE;

    // Operation decode: selects the write slot, next pointer/count/top and
    // which error flag (if any) this cycle raises.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_idx  = r_ptr;
        w_ptr_nxt = r_ptr;
        w_cnt_nxt = r_count;
        w_top_nxt = r_top;
        w_set_ov  = 1'b0;
        w_set_un  = 1'b0;

        if (en) begin
            if (push && pop) begin
                // Replace-top; on an empty stack this degenerates to a push
                // into the slot r_ptr already designates.
                w_wr_en   = 1'b1;
                w_wr_idx  = r_ptr;
                w_top_nxt = din;
                if (w_empty) begin
                    w_cnt_nxt = c_CNT_ONE;
                end
            end else if (push) begin
                if (w_empty) begin
                    w_wr_en   = 1'b1;
                    w_wr_idx  = r_ptr;
                    w_cnt_nxt = c_CNT_ONE;
                    w_top_nxt = din;
                end else if (!w_full) begin
                    w_wr_en   = 1'b1;
                    w_wr_idx  = w_ptr_inc;
                    w_ptr_nxt = w_ptr_inc;
                    w_cnt_nxt = r_count + c_CNT_ONE;
                    w_top_nxt = din;
                end else begin
                    w_set_ov = 1'b1;
                    if (OVERWRITE != 0) begin
                        // Circular: the slot past the top is the oldest
                        // entry, so writing it discards the bottom.
                        w_wr_en   = 1'b1;
                        w_wr_idx  = w_ptr_inc;
                        w_ptr_nxt = w_ptr_inc;
                        w_top_nxt = din;
                    end
                end
            end else if (pop) begin
                if (w_empty) begin
                    w_set_un = 1'b1;
                end else if (r_count == c_CNT_ONE) begin
                    // Pointer stays so the next push reuses this slot.
                    w_cnt_nxt = c_CNT_ZERO;
                    w_top_nxt = c_TOP_ZERO;
                end else begin
                    w_ptr_nxt = w_ptr_dec;
                    w_cnt_nxt = r_count - c_CNT_ONE;
                    w_top_nxt = r_mem[w_ptr_dec];
                end
            end
        end
    end

    // Sticky flags: err_clr clears regardless of en, a same-cycle set wins.
    assign w_ov_nxt = (r_overflow  & ~err_clr) | w_set_ov;
    assign w_un_nxt = (r_underflow & ~err_clr) | w_set_un;

    // Control registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_ptr       <= '0;
            r_count     <= '0;
            r_top       <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_ptr       <= w_ptr_nxt;
            r_count     <= w_cnt_nxt;
            r_top       <= w_top_nxt;
            r_overflow  <= w_ov_nxt;
            r_underflow <= w_un_nxt;
        end
    end

    // Storage array; not reset since unoccupied entries are don't-care.
    always_ff @(posedge clk) begin
        if (clr && w_wr_en) begin
            r_mem[w_wr_idx] <= din;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign top       = r_top;
    assign count     = r_count;
    assign empty     = w_empty;
    assign full      = w_full;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_lifo_stack.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lifo_stack
//  Description : Self-checking bench for lifo_stack. Two instances (drop and
//                circular mode) share stimulus; a queue-based reference
//                model predicts each cycle and a scoreboard compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lifo_stack;

    localparam int c_W  = 8;
    localparam int c_DL = 2;

    typedef struct packed {
        logic [7:0] top;
        logic [2:0] count;
        logic       empty;
        logic       full;
        logic       ov;
        logic       un;
    } exp_t;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       en = 1'b0, push = 1'b0, pop = 1'b0, err_clr = 1'b0;
    logic [7:0] din = 8'h00;

    logic [7:0] top0, top1;
    logic [2:0] count0, count1;
    logic       empty0, full0, overflow0, underflow0;
    logic       empty1, full1, overflow1, underflow1;

    int checks = 0;
    int errors = 0;
    string cur_test = "none";

    // reference model state
    logic [7:0] m_stk0[$], m_stk1[$], wq[$];
    bit         m_ov0, m_un0, m_ov1, m_un1, wov, wun;
    exp_t       exp_q0[$], exp_q1[$];
    bit         sb_valid = 1'b0;

    lifo_stack #(.WIDTH(c_W), .DEPTH_LOG2(c_DL), .OVERWRITE(0)) u_drop (
        .clk(clk), .clr(clr), .en(en), .push(push), .pop(pop), .din(din),
        .err_clr(err_clr), .top(top0), .count(count0), .empty(empty0),
        .full(full0), .overflow(overflow0), .underflow(underflow0)
    );

    lifo_stack #(.WIDTH(c_W), .DEPTH_LOG2(c_DL), .OVERWRITE(1)) u_circ (
        .clk(clk), .clr(clr), .en(en), .push(push), .pop(pop), .din(din),
        .err_clr(err_clr), .top(top1), .count(count1), .empty(empty1),
        .full(full1), .overflow(overflow1), .underflow(underflow1)
    );

    always #5 clk = ~clk;

    // Reference behaviour of one stack on the working queue wq (back = top).
    task automatic model_apply(input bit ovw, input bit e, input bit pu,
                               input bit po, input logic [7:0] d, input bit ec);
        bit was_empty = (wq.size() == 0);
        bit was_full  = (wq.size() == 4);
        if (ec) begin
            wov = 1'b0;
            wun = 1'b0;
        end
        if (e) begin
            if (pu && po) begin
                if (was_empty) wq.push_back(d);
                else wq[wq.size()-1] = d;
            end else if (pu) begin
                if (!was_full) begin
                    wq.push_back(d);
                end else begin
                    wov = 1'b1;
                    if (ovw) begin
                        void'(wq.pop_front());
                        wq.push_back(d);
                    end
                end
            end else if (po) begin
                if (was_empty) wun = 1'b1;
                else void'(wq.pop_back());
            end
        end
    endtask

    function automatic exp_t make_exp();
        exp_t e;
        e.top   = (wq.size() > 0) ? wq[wq.size()-1] : 8'h00;
        e.count = 3'(wq.size());
        e.empty = (wq.size() == 0);
        e.full  = (wq.size() == 4);
        e.ov    = wov;
        e.un    = wun;
        return e;
    endfunction

    // Drive one operation at the falling edge and queue its expected result.
    task automatic drive_op(input bit e, input bit pu, input bit po,
                            input logic [7:0] d, input bit ec);
        @(negedge clk);
        en = e; push = pu; pop = po; din = d; err_clr = ec;
        wq = m_stk0; wov = m_ov0; wun = m_un0;
        model_apply(1'b0, e, pu, po, d, ec);
        m_stk0 = wq; m_ov0 = wov; m_un0 = wun;
        exp_q0.push_back(make_exp());
        wq = m_stk1; wov = m_ov1; wun = m_un1;
        model_apply(1'b1, e, pu, po, d, ec);
        m_stk1 = wq; m_ov1 = wov; m_un1 = wun;
        exp_q1.push_back(make_exp());
        sb_valid = 1'b1;
        @(posedge clk);
        #2;
        sb_valid = 1'b0;
        en = 1'b0; push = 1'b0; pop = 1'b0; err_clr = 1'b0;
    endtask

    // Scoreboard: pops the expectation for the edge just taken and compares.
    always @(posedge clk) begin
        if (sb_valid) begin
            exp_t e0, e1, a0, a1;
            #1;
            a0 = {top0, count0, empty0, full0, overflow0, underflow0};
            a1 = {top1, count1, empty1, full1, overflow1, underflow1};
            checks = checks + 2;
            if (exp_q0.size() == 0 || exp_q1.size() == 0) begin
                errors = errors + 2;
                $display("FAIL sb_empty (%s): got no expectation queued", cur_test);
            end else begin
                e0 = exp_q0.pop_front();
                e1 = exp_q1.pop_front();
                if (a0 !== e0) begin
                    errors = errors + 1;
                    $display("FAIL sb_drop (%s): got top=%h cnt=%0d e=%b f=%b ov=%b un=%b, want top=%h cnt=%0d e=%b f=%b ov=%b un=%b",
                             cur_test, a0.top, a0.count, a0.empty, a0.full, a0.ov, a0.un,
                             e0.top, e0.count, e0.empty, e0.full, e0.ov, e0.un);
                end
                if (a1 !== e1) begin
                    errors = errors + 1;
                    $display("FAIL sb_circ (%s): got top=%h cnt=%0d e=%b f=%b ov=%b un=%b, want top=%h cnt=%0d e=%b f=%b ov=%b un=%b",
                             cur_test, a1.top, a1.count, a1.empty, a1.full, a1.ov, a1.un,
                             e1.top, e1.count, e1.empty, e1.full, e1.ov, e1.un);
                end
            end
        end
    end

    task automatic release_reset();
        @(negedge clk);
        en = 1'b0; push = 1'b0; pop = 1'b0; err_clr = 1'b0;
        clr = 1'b1;
        m_stk0.delete(); m_stk1.delete();
        m_ov0 = 0; m_un0 = 0; m_ov1 = 0; m_un1 = 0;
        exp_q0.delete(); exp_q1.delete();
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        clr = 1'b0;
        #1;
        release_reset();
    endtask

    task automatic test_reset();
        cur_test = "reset";
        en = 1'b1; push = 1'b1; pop = 1'b1; din = 8'hFF; err_clr = 1'b0;
        clr = 1'b0;
        @(posedge clk);
        #1;
        checks = checks + 1;
        if ({top0, count0, empty0, full0, overflow0, underflow0} !== {8'h00, 3'd0, 4'b1000} ||
            {top1, count1, empty1, full1, overflow1, underflow1} !== {8'h00, 3'd0, 4'b1000}) begin
            errors = errors + 1;
            $display("FAIL reset_state: got drop top=%h cnt=%0d efou=%b%b%b%b circ top=%h cnt=%0d, want top=00 cnt=0 efou=1000",
                     top0, count0, empty0, full0, overflow0, underflow0, top1, count1);
        end
        release_reset();
    endtask

    task automatic test_fill();
        cur_test = "fill";
        drive_op(1, 1, 0, 8'h11, 0);
        drive_op(1, 1, 0, 8'h22, 0);
        drive_op(1, 1, 0, 8'h33, 0);
        drive_op(1, 1, 0, 8'h44, 0);
        checks = checks + 1;
        if ({top0, count0, full0} !== {8'h44, 3'd4, 1'b1}) begin
            errors = errors + 1;
            $display("FAIL fill_full: got top=%h cnt=%0d full=%b, want top=44 cnt=4 full=1", top0, count0, full0);
        end
    endtask

    task automatic test_overflow_drop();
        cur_test = "overflow_drop";
        drive_op(1, 1, 0, 8'h55, 0);
        checks = checks + 1;
        if ({top0, count0, overflow0} !== {8'h44, 3'd4, 1'b1}) begin
            errors = errors + 1;
            $display("FAIL drop_push: got top=%h cnt=%0d ov=%b, want top=44 cnt=4 ov=1", top0, count0, overflow0);
        end
        for (int i = 0; i < 4; i++) drive_op(1, 0, 1, 8'h00, 0);
        checks = checks + 1;
        if ({top0, empty0} !== {8'h00, 1'b1}) begin
            errors = errors + 1;
            $display("FAIL drain_empty: got top=%h empty=%b, want top=00 empty=1", top0, empty0);
        end
        drive_op(1, 0, 1, 8'h00, 0);
        checks = checks + 1;
        if ({underflow0, count0} !== {1'b1, 3'd0}) begin
            errors = errors + 1;
            $display("FAIL underflow_set: got un=%b cnt=%0d, want un=1 cnt=0", underflow0, count0);
        end
    endtask

    task automatic test_overwrite();
        cur_test = "overwrite";
        pulse_reset();
        for (int i = 1; i <= 5; i++) drive_op(1, 1, 0, 8'(i), 0);
        checks = checks + 1;
        if ({top1, count1, overflow1} !== {8'h05, 3'd4, 1'b1}) begin
            errors = errors + 1;
            $display("FAIL circ_push: got top=%h cnt=%0d ov=%b, want top=05 cnt=4 ov=1", top1, count1, overflow1);
        end
        drive_op(1, 0, 1, 8'h00, 0);
        drive_op(1, 0, 1, 8'h00, 0);
        drive_op(1, 0, 1, 8'h00, 0);
        checks = checks + 1;
        if ({top1, count1} !== {8'h02, 3'd1}) begin
            errors = errors + 1;
            $display("FAIL circ_pop3: got top=%h cnt=%0d, want top=02 cnt=1", top1, count1);
        end
        drive_op(1, 0, 1, 8'h00, 0);
    endtask

    task automatic test_simultaneous();
        cur_test = "simultaneous";
        pulse_reset();
        drive_op(1, 1, 0, 8'hA0, 0);
        drive_op(1, 1, 1, 8'hB0, 0);
        checks = checks + 1;
        if ({top0, count0} !== {8'hB0, 3'd1}) begin
            errors = errors + 1;
            $display("FAIL replace_top: got top=%h cnt=%0d, want top=B0 cnt=1", top0, count0);
        end
        pulse_reset();
        drive_op(1, 1, 1, 8'hC0, 0);
        checks = checks + 1;
        if ({top0, count0, underflow0} !== {8'hC0, 3'd1, 1'b0}) begin
            errors = errors + 1;
            $display("FAIL pushpop_empty: got top=%h cnt=%0d un=%b, want top=C0 cnt=1 un=0", top0, count0, underflow0);
        end
    endtask

    task automatic test_enable_errclr();
        cur_test = "enable_errclr";
        drive_op(1, 0, 1, 8'h00, 0);
        drive_op(1, 0, 1, 8'h00, 0);
        drive_op(0, 1, 0, 8'h77, 0);
        checks = checks + 1;
        if ({top0, count0, underflow0} !== {8'h00, 3'd0, 1'b1}) begin
            errors = errors + 1;
            $display("FAIL en_low_hold: got top=%h cnt=%0d un=%b, want top=00 cnt=0 un=1", top0, count0, underflow0);
        end
        drive_op(1, 0, 1, 8'h00, 1);
        checks = checks + 1;
        if (underflow0 !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL set_wins: got un=%b, want un=1", underflow0);
        end
        drive_op(0, 0, 0, 8'h00, 1);
        checks = checks + 1;
        if (underflow0 !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL err_clr: got un=%b, want un=0", underflow0);
        end
        for (int i = 0; i < 5; i++) drive_op(1, 1, 0, 8'h60 + 8'(i), 0);
        drive_op(0, 0, 0, 8'h00, 1);
        checks = checks + 1;
        if ({overflow0, overflow1, count0} !== {1'b0, 1'b0, 3'd4}) begin
            errors = errors + 1;
            $display("FAIL ov_clr_en_low: got ov=%b/%b cnt=%0d, want ov=0/0 cnt=4", overflow0, overflow1, count0);
        end
    endtask

    task automatic test_async_reset();
        cur_test = "async_reset";
        pulse_reset();
        drive_op(1, 1, 0, 8'h21, 0);
        drive_op(1, 1, 0, 8'h22, 0);
        drive_op(1, 1, 0, 8'h23, 0);
        @(negedge clk);
        #2;
        en = 1'b1; push = 1'b1; din = 8'h99;
        clr = 1'b0;
        #1;
        checks = checks + 1;
        if ({top0, count0, empty0, full0, overflow0, underflow0} !== {8'h00, 3'd0, 4'b1000} ||
            {top1, count1, empty1} !== {8'h00, 3'd0, 1'b1}) begin
            errors = errors + 1;
            $display("FAIL async_clr: got top=%h cnt=%0d empty=%b circ top=%h cnt=%0d, want top=00 cnt=0 empty=1",
                     top0, count0, empty0, top1, count1);
        end
        release_reset();
        drive_op(1, 1, 0, 8'h5A, 0);
    endtask

    task automatic test_back_to_back();
        cur_test = "back_to_back";
        for (int i = 0; i < 300; i++) begin
            bit e  = ($urandom_range(0, 9) != 0);
            bit pu = ($urandom_range(0, 9) < 6);
            bit po = ($urandom_range(0, 9) < 5);
            bit ec = ($urandom_range(0, 9) == 0);
            drive_op(e, pu, po, 8'($urandom), ec);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow_drop();
        test_overwrite();
        test_simultaneous();
        test_enable_errclr();
        test_async_reset();
        test_back_to_back();
        repeat (2) @(negedge clk);
        checks = checks + 1;
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            errors = errors + 1;
            $display("FAIL sb_leftover: got %0d/%0d pending, want 0", exp_q0.size(), exp_q1.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
